block_deinterleaver: RTL and testbench

- Serial-bit row-column block deinterleaver: the receive-side inverse of the team's ROWS x COLS block interleaver.
- The interleaver writes row-wise and reads column-wise; this block restores the original bit order.
- Sits after the demodulator/slicer and before the channel decoder.
- Ping-pong bit buffers: one bank fills while the previous block is read out. Adds block sync, valid/ready and flush (drain) handling.

---
 rtl/block_deinterleaver.sv | 122 ++++++++++++
 tb/tb_block_deinterleaver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/block_deinterleaver.sv
`default_nettype none
// block_deinterleaver: serial-bit ROWS x COLS row-column block deinterleaver
// with ping-pong bit banks, block sync, valid/ready and flush drain. Rev 1.0
module block_deinterleaver #(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic data_i,
  input  logic sof_i,
  input  logic flush_i,
  output logic data_o,
  output logic out_valid,
  output logic out_sof,
  output logic sync_err
);

  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(N);

  localparam logic [1:0] S_EMPTY  = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          wr_bank, wr_bank_nxt;
  logic [N-1:0]  bank0, bank1, rd_word;
  logic          beat, last, resync;
  logic          we, emit;
  logic [CW-1:0] waddr;

  // Output position i was written column-wise by the interleaver.
  function automatic logic [CW-1:0] perm(input logic [CW-1:0] i);
    int idx;
    idx = (int'(i) % COLS) * ROWS + int'(i) / COLS;
    return idx[CW-1:0];
  endfunction

  assign beat    = in_valid && in_ready;
  assign last    = (cnt == CW'(N - 1));
  assign resync  = beat && sof_i && (cnt != '0);
  assign rd_word = wr_bank ? bank0 : bank1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_EMPTY;
      cnt     <= '0;
      wr_bank <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wr_bank <= wr_bank_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    wr_bank_nxt = wr_bank;
    case (state)
      S_EMPTY, S_STREAM: begin
        if (resync) begin
          // Misplaced sof: the offending bit becomes bit 0 of a fresh block.
          state_nxt = S_EMPTY;
          cnt_nxt   = CW'(1);
        end else if (beat) begin
          if (last) begin
            cnt_nxt     = '0;
            wr_bank_nxt = ~wr_bank;
            state_nxt   = S_STREAM;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if (state == S_STREAM && flush_i && cnt == '0) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last) begin
          cnt_nxt   = '0;
          state_nxt = S_EMPTY;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    in_ready = (state != S_DRAIN);
    we       = beat;
    waddr    = resync ? '0 : cnt;
    emit     = (state == S_STREAM && beat && !resync) || (state == S_DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank0     <= '0;
      bank1     <= '0;
      data_o    <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      if (we) begin
        if (wr_bank) bank1[waddr] <= data_i;
        else         bank0[waddr] <= data_i;
      end
      data_o    <= emit && rd_word[perm(cnt)];
      out_valid <= emit;
      out_sof   <= emit && (cnt == '0);
      sync_err  <= resync;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_deinterleaver.sv
`default_nettype none
// tb_block_deinterleaver: scoreboard bench for a 4x4 and a 2x8 deinterleaver.
// Rev 1.0
module tb_block_deinterleaver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;
  logic in_valid = 1'b0, data = 1'b0, sof = 1'b0, flush = 1'b0;
  logic a_rdy, a_do, a_ov, a_sof, a_err;
  logic b_rdy, b_do, b_ov, b_sof, b_err;
  logic m_rdy, m_do, m_ov, m_sof, m_err;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0]  q[$];
  logic        ev = 1'b0, ee = 1'b0, ev_d, ee_d;
  logic [15:0] prev = '0;
  bit          have_prev = 0;

  always #5 clk = ~clk;

  block_deinterleaver #(.ROWS(4), .COLS(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(a_rdy),
    .data_i(data), .sof_i(sof), .flush_i(flush & ~sel),
    .data_o(a_do), .out_valid(a_ov), .out_sof(a_sof), .sync_err(a_err));

  block_deinterleaver #(.ROWS(2), .COLS(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(b_rdy),
    .data_i(data), .sof_i(sof), .flush_i(flush & sel),
    .data_o(b_do), .out_valid(b_ov), .out_sof(b_sof), .sync_err(b_err));

  assign m_rdy = sel ? b_rdy : a_rdy;
  assign m_do  = sel ? b_do  : a_do;
  assign m_ov  = sel ? b_ov  : a_ov;
  assign m_sof = sel ? b_sof : a_sof;
  assign m_err = sel ? b_err : a_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Interleaver model: write row-wise, read column-wise.
  function automatic logic [15:0] interleave(input logic [15:0] orig);
    logic [15:0] il;
    int rows, cols;
    rows = sel ? 2 : 4;
    cols = sel ? 8 : 4;
    il = '0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        il[c*rows + r] = orig[r*cols + c];
    return il;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_d <= 1'b0;
      ee_d <= 1'b0;
    end else begin
      ev_d <= ev;
      ee_d <= ee;
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (rst) begin
      check("out_valid", m_ov, ev_d);
      check("sync_err", m_err, ee_d);
      if (m_ov) begin
        if (q.size() == 0) check("spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          check("data_o", m_do, e[0]);
          check("out_sof", m_sof, e[1]);
        end
      end
    end
  end

  task automatic step(input logic v, input logic d, input logic s, input logic f,
                      input logic pv, input logic pb, input logic ps, input logic pe);
    in_valid = v; data = d; sof = s; flush = f; ev = pv; ee = pe;
    if (pv) q.push_back({ps, pb});
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input logic s);
    rst = 1'b0; in_valid = 0; flush = 0; sof = 0; data = 0; ev = 0; ee = 0;
    sel = s; q.delete(); have_prev = 0;
    #1;
    check("rst_out_valid", m_ov, 0);
    check("rst_data_o", m_do, 0);
    check("rst_out_sof", m_sof, 0);
    check("rst_sync_err", m_err, 0);
    check("rst_in_ready", m_rdy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic send_block(input logic [15:0] orig, input bit gaps);
    logic [15:0] il;
    il = interleave(orig);
    for (int i = 0; i < 16; i++) begin
      if (gaps)
        for (int g = 0; g < 4; g++) begin
          if ($urandom_range(1, 0) != 0) break;
          idle();
        end
      check("in_ready", m_rdy, 1);
      step(1, il[i], i == 0, 0, have_prev, prev[i], i == 0, 0);
    end
    prev = orig;
    have_prev = 1;
  endtask

  task automatic drain();
    step(0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      check("drain_in_ready", m_rdy, 0);
      step(0, 0, 0, 0, 1, prev[i], i == 0, 0);
    end
    check("post_drain_in_ready", m_rdy, 1);
    have_prev = 0;
  endtask

  task automatic finish_test(input string tag);
    idle(); idle();
    check(tag, q.size(), 0);
  endtask

  initial begin
    logic [15:0] il;
    // single set bit, 4x4: original bit 4 <-> interleaved bit 1
    do_reset(0);
    send_block(16'h0010, 0);
    send_block(16'h0000, 0);
    finish_test("q_single_bit");

    do_reset(0);
    send_block(16'hA5C3, 0);
    send_block(16'h0F0F, 0);
    send_block(16'hFFFF, 0);
    finish_test("q_continuous");

    do_reset(0);
    send_block(16'hA5C3, 1);
    send_block(16'h0F0F, 1);
    send_block(16'hFFFF, 1);
    finish_test("q_random_valid");

    // sof at beat 7 of block 2 restarts a block with that beat as bit 0
    do_reset(0);
    send_block(16'h1234, 0);
    il = interleave(16'hBEEF);
    for (int i = 0; i < 7; i++) step(1, il[i], i == 0, 0, 1, prev[i], i == 0, 0);
    il = interleave(16'h5A3C);
    step(1, il[0], 1, 0, 0, 0, 0, 1);
    for (int i = 1; i < 16; i++) step(1, il[i], 0, 0, 0, 0, 0, 0);
    prev = 16'h5A3C;
    have_prev = 1;
    send_block(16'hFFFF, 0);
    finish_test("q_sync");

    // reset in the middle of streaming, then drain a fresh block
    do_reset(0);
    send_block(16'h0F00, 0);
    il = interleave(16'h1111);
    for (int i = 0; i < 9; i++) step(1, il[i], i == 0, 0, 1, prev[i], i == 0, 0);
    do_reset(0);
    send_block(16'hC3A5, 0);
    idle(); idle();
    drain();
    finish_test("q_mid_reset");

    // 2x8: original bit 8 <-> interleaved bit 1, drained by flush
    do_reset(1);
    send_block(16'h0100, 0);
    drain();
    finish_test("q_flush_2x8");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
